// File: rtl/dc_coeff_scheduler_if.sv
// Scheduler-facing bus: coefficient buffer read port, DC encoder feed/return, and bit-packer output.
// The master modport is the scheduler side; slave is the surrounding buffer/encoder/packer.
interface dc_coeff_scheduler_if #(
    parameter int COEFF_W = 20,
    parameter int BLK_AW  = 6,
    parameter int CODE_W  = 24,
    parameter int LEN_W   = 6
);
    logic                start;
    logic [BLK_AW:0]     num_blocks;
    logic                busy;
    logic                done;
    logic                coeff_rd_en;
    logic [BLK_AW-1:0]   coeff_rd_addr;
    logic [COEFF_W-1:0]  coeff_rd_data;
    logic                enc_valid;
    logic [COEFF_W-1:0]  enc_coeff;
    logic                enc_first;
    logic                enc_code_valid;
    logic [CODE_W-1:0]   enc_code;
    logic [LEN_W-1:0]    enc_len;
    logic                out_valid;
    logic [CODE_W-1:0]   out_code;
    logic [LEN_W-1:0]    out_len;
    logic                out_last;
    logic                out_ready;
    logic                overflow;

    modport master (
        input  start, num_blocks, coeff_rd_data, enc_code_valid, enc_code, enc_len, out_ready,
        output busy, done, coeff_rd_en, coeff_rd_addr, enc_valid, enc_coeff, enc_first,
               out_valid, out_code, out_len, out_last, overflow
    );

    modport slave (
        output start, num_blocks, coeff_rd_data, enc_code_valid, enc_code, enc_len, out_ready,
        input  busy, done, coeff_rd_en, coeff_rd_addr, enc_valid, enc_coeff, enc_first,
               out_valid, out_code, out_len, out_last, overflow
    );
endinterface

// File: rtl/dc_coeff_scheduler.sv
// DC coefficient sequencer: read -> encoder -> credit-protected result FIFO -> packer.
// First codeword 1+ENC_LAT+1 cycles after the first read; packer stalls throttle reads via credits.

module dc_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         head_vld,
    output logic         full,
    output logic         drop
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          wr_en;
    logic          rd_en;

    assign head_vld = (cnt != '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign rd_en    = pop_rdy && head_vld;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign wr_en    = push_vld && (!full || rd_en);
    assign drop     = push_vld && !wr_en;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

module dc_coeff_scheduler #(
    parameter int COEFF_W = 20,
    parameter int BLK_AW  = 6,
    parameter int CODE_W  = 24,
    parameter int LEN_W   = 6,
    parameter int ENC_LAT = 4,
    parameter int FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dc_coeff_scheduler_if.master bus
);
    localparam int DEPTH = 2 ** FIFO_AW;

    if (ENC_LAT < 1 || FIFO_AW < 1) begin : g_bad_params
        $error("dc_coeff_scheduler: ENC_LAT and FIFO_AW must both be at least 1");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } res_t;

    state_t          state;
    logic [BLK_AW:0] num_lat;
    logic [BLK_AW:0] issued;
    logic [BLK_AW:0] returned;
    logic [BLK_AW:0] popped;
    logic [BLK_AW:0] popped_nxt;
    logic [BLK_AW:0] credit;
    logic            rd_fire;
    logic            push_vld;
    logic            pop_rdy;
    logic            fifo_vld;
    logic            fifo_full;
    logic            fifo_drop;
    logic            enc_vld_q;
    logic            enc_first_q;
    logic            overflow_q;
    res_t            push_dat;
    res_t            head_dat;

    // Credits cover reads in flight, encoder pipeline and FIFO occupancy alike.
    assign credit     = issued - popped;
    assign rd_fire    = (state == FETCH) && (issued < num_lat) && (credit < (BLK_AW+1)'(DEPTH));
    assign push_vld   = bus.enc_code_valid && (state != IDLE);
    assign pop_rdy    = fifo_vld && bus.out_ready;
    assign popped_nxt = popped + (BLK_AW+1)'(pop_rdy);
    assign push_dat   = '{code: bus.enc_code, len: bus.enc_len};

    dc_fifo #(.W($bits(res_t)), .AW(FIFO_AW)) u_res_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .head_vld (fifo_vld),
        .full     (fifo_full),
        .drop     (fifo_drop)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            num_lat     <= '0;
            issued      <= '0;
            returned    <= '0;
            popped      <= '0;
            enc_vld_q   <= 1'b0;
            enc_first_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            enc_vld_q   <= rd_fire;
            enc_first_q <= rd_fire && (issued == '0);
            if (fifo_drop) overflow_q <= 1'b1;
            if (rd_fire)   issued     <= issued + (BLK_AW+1)'(1);
            if (push_vld)  returned   <= returned + (BLK_AW+1)'(1);
            if (pop_rdy)   popped     <= popped_nxt;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        num_lat  <= bus.num_blocks;
                        issued   <= '0;
                        returned <= '0;
                        popped   <= '0;
                        state    <= (bus.num_blocks == '0) ? DONE : FETCH;
                    end
                end
                FETCH: if (issued == num_lat) state <= DRAIN;
                // Look ahead on the pop so done lands the cycle after the final pop.
                DRAIN: if (popped_nxt == num_lat) state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.coeff_rd_en   = rd_fire;
    assign bus.coeff_rd_addr = rd_fire ? issued[BLK_AW-1:0] : '0;
    assign bus.enc_valid     = enc_vld_q;
    assign bus.enc_first     = enc_first_q;
    assign bus.enc_coeff     = enc_vld_q ? bus.coeff_rd_data : '0;
    assign bus.out_valid     = fifo_vld;
    assign bus.out_code      = fifo_vld ? head_dat.code : '0;
    assign bus.out_len       = fifo_vld ? head_dat.len : '0;
    assign bus.out_last      = fifo_vld && (popped == num_lat - (BLK_AW+1)'(1));
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_dc_coeff_scheduler.sv
// Scoreboard bench: slice tasks queue expected reads, encoder feeds and codewords; negedge monitor pops and compares.
module tb_dc_coeff_scheduler;
    localparam int ENC_LAT = 4;

    typedef struct packed {
        logic [23:0] code;
        logic [5:0]  len;
        logic        last;
    } exp_out_t;

    typedef struct packed {
        logic        first;
        logic [19:0] coeff;
    } exp_enc_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dc_coeff_scheduler_if bus ();
    dc_coeff_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    exp_out_t    exp_out_q[$];
    exp_enc_t    exp_enc_q[$];
    int          exp_addr_q[$];
    exp_out_t    mo;
    exp_enc_t    me;
    logic [19:0] mem [64];

    int   n_checks = 0, n_pass = 0, cyc = 0;
    int   reads = 0, enc_pulses = 0, done_cnt = 0;
    int   cur_n = 0, start_cyc = 0, first_rd_cyc = 0, last_pop_cyc = 0;
    bit   seen_out = 0;
    bit   rdy_mode = 0;
    logic rdy_val = 1'b1;
    int   pcnt = 0, inj_req = 0, inj_ack = 0;
    logic pv [ENC_LAT];
    int   pk [ENC_LAT];
    int   kcnt = 0, rd_addr = 0;
    logic rd_pend = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_done"},      bus.done, 0);
        chk({tag, "_rd_en"},     bus.coeff_rd_en, 0);
        chk({tag, "_enc_valid"}, bus.enc_valid, 0);
        chk({tag, "_enc_first"}, bus.enc_first, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_last"},  bus.out_last, 0);
        chk({tag, "_out_code"},  bus.out_code, 0);
        chk({tag, "_overflow"},  bus.overflow, 0);
    endtask

    task automatic begin_slice(input int n);
        for (int k = 0; k < n; k++) begin
            exp_addr_q.push_back(k);
            exp_enc_q.push_back('{first: (k == 0), coeff: mem[k]});
            exp_out_q.push_back('{code: 24'(k), len: 6'(k + 1), last: (k == n - 1)});
        end
        reads = 0; enc_pulses = 0; seen_out = 0; cur_n = n;
        bus.start = 1'b1;
        bus.num_blocks = 7'(n);
        start_cyc = cyc;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int  d0;
        bit  ok;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (done_cnt != d0) begin ok = 1; break; end
        end
        chk({tag, "_done_seen"}, ok, 1);
        chk({tag, "_done_width"}, bus.done, 0);
        chk({tag, "_busy_after"}, bus.busy, 0);
        chk({tag, "_left_reads"}, exp_addr_q.size(), 0);
        chk({tag, "_left_codes"}, exp_out_q.size(), 0);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Coefficient buffer and fixed-latency encoder models: sample at negedge, drive after posedge.
    always @(negedge clk) begin
        rd_pend = bus.coeff_rd_en;
        rd_addr = int'(bus.coeff_rd_addr);
        for (int i = ENC_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pk[i] = pk[i-1];
        end
        pv[0] = bus.enc_valid;
        pk[0] = 0;
        if (bus.enc_valid) begin
            pk[0] = bus.enc_first ? 0 : kcnt;
            kcnt  = pk[0] + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        bus.coeff_rd_data  = rd_pend ? mem[rd_addr] : 20'd0;
        bus.enc_code_valid = pv[ENC_LAT-1];
        bus.enc_code       = 24'(pk[ENC_LAT-1]);
        bus.enc_len        = 6'(pk[ENC_LAT-1] + 1);
        if (inj_req != inj_ack) begin
            bus.enc_code_valid = 1'b1;
            bus.enc_code       = 24'hABCDEF;
            bus.enc_len        = 6'd9;
            inj_ack            = inj_req;
        end
        if (rdy_mode) begin
            bus.out_ready = (pcnt == 0 || pcnt == 3);
            pcnt = (pcnt + 1) % 4;
        end else begin
            bus.out_ready = rdy_val;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.coeff_rd_en) begin
                reads++;
                if (reads == 1) first_rd_cyc = cyc;
                if (exp_addr_q.size() > 0) chk("rd_addr", bus.coeff_rd_addr, exp_addr_q.pop_front());
                else chk("rd_unexpected_queue", exp_addr_q.size(), 1);
            end
            if (bus.enc_valid) begin
                enc_pulses++;
                if (exp_enc_q.size() > 0) begin
                    me = exp_enc_q.pop_front();
                    chk("enc_coeff", bus.enc_coeff, me.coeff);
                    chk("enc_first", bus.enc_first, me.first);
                end else chk("enc_unexpected_queue", exp_enc_q.size(), 1);
            end
            if (bus.out_valid) begin
                if (!seen_out) begin
                    seen_out = 1;
                    chk("first_out_latency", cyc - first_rd_cyc, 1 + ENC_LAT + 1);
                end
                if (exp_out_q.size() > 0) begin
                    mo = exp_out_q[0];
                    chk("out_code", bus.out_code, mo.code);
                    chk("out_len",  bus.out_len,  mo.len);
                    chk("out_last", bus.out_last, mo.last);
                    if (bus.out_ready) begin
                        void'(exp_out_q.pop_front());
                        last_pop_cyc = cyc;
                    end
                end else chk("out_unexpected_queue", exp_out_q.size(), 1);
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_timing", cyc, (cur_n == 0) ? start_cyc + 1 : last_pop_cyc + 1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 20'(i * 1237 - 40000);
        mem[0] = 20'd100; mem[1] = 20'd104; mem[2] = 20'd98; mem[3] = 20'd98;
        for (int i = 0; i < ENC_LAT; i++) begin pv[i] = 1'b0; pk[i] = 0; end
        reset_n = 1'b0;
        bus.start = 1'b0; bus.num_blocks = '0; bus.out_ready = 1'b1;
        bus.coeff_rd_data = '0; bus.enc_code_valid = 1'b0; bus.enc_code = '0; bus.enc_len = '0;
        tick(2);
        check_quiet("reset");
        reset_n = 1'b1;
        tick(2);

        // Basic slice, packer always ready.
        begin_slice(4);
        wait_done("basic");
        chk("basic_returned", dut.returned, enc_pulses);
        chk("basic_enc_pulses", enc_pulses, 4);

        // Credit limit under a fully stalled packer.
        rdy_val = 1'b0;
        begin_slice(16);
        tick(30);
        chk("credit_reads_held", reads, 4);
        chk("credit_rd_en_low", bus.coeff_rd_en, 0);
        chk("credit_out_valid", bus.out_valid, 1);
        chk("credit_overflow", bus.overflow, 0);
        rdy_val = 1'b1;
        wait_done("credit");
        chk("credit_reads_total", reads, 16);
        chk("credit_returned", dut.returned, enc_pulses);
        chk("credit_overflow_end", bus.overflow, 0);

        // Ready pattern 1,0,0,1 repeating.
        rdy_mode = 1;
        pcnt = 0;
        begin_slice(8);
        wait_done("stall");
        rdy_mode = 0;

        begin_slice(0);
        wait_done("zero");
        chk("zero_reads", reads, 0);

        begin_slice(64);
        wait_done("max");
        chk("max_reads", reads, 64);

        // Start during DRAIN is ignored; extra result into a full FIFO trips overflow.
        rdy_val = 1'b0;
        begin_slice(4);
        tick(15);
        chk("err_busy", bus.busy, 1);
        bus.start = 1'b1;
        bus.num_blocks = 7'd2;
        tick(1);
        bus.start = 1'b0;
        tick(3);
        chk("err_reads_after_start", reads, 4);
        chk("err_overflow_before", bus.overflow, 0);
        inj_req++;
        tick(2);
        chk("err_overflow_set", bus.overflow, 1);
        rdy_val = 1'b1;
        wait_done("err");
        chk("err_overflow_sticky", bus.overflow, 1);

        // Asynchronous reset in the middle of a stalled fetch.
        rdy_val = 1'b0;
        begin_slice(16);
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid) break;
            tick(1);
        end
        chk("rst_fill_started", bus.out_valid, 1);
        tick(2);
        chk("rst_busy_before", bus.busy, 1);
        begin
            int d0;
            d0 = done_cnt;
            reset_n = 1'b0;
            #1;
            check_quiet("midreset");
            exp_addr_q.delete();
            exp_enc_q.delete();
            exp_out_q.delete();
            tick(3);
            reset_n = 1'b1;
            tick(10);
            chk("rst_no_done", done_cnt, d0);
            chk("rst_late_not_counted", dut.returned, 0);
            chk("rst_idle_out_valid", bus.out_valid, 0);
        end
        rdy_val = 1'b1;
        begin_slice(4);
        wait_done("post_reset");
        chk("post_reset_returned", dut.returned, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
